sort4_ctrl: RTL and testbench
=============================

SORT4_CTRL -- requirements
Module: sort4_ctrl

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning the number of 4-bit entries per sort job; legal range is 2..8.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: in_data holds a valid entry.
REQ-005 The block SHALL have port in_data, input, 4 bits: unsigned entry to load.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept an entry this cycle.
REQ-007 The block SHALL have port out_valid, output, 1 bit: out_data holds a valid sorted entry.
REQ-008 The block SHALL have port out_data, output, 4 bits: sorted entry, ascending order.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer accepts out_data this cycle.
REQ-010 The block SHALL have port busy, output, 1 bit: high while in state SORT.
REQ-011 The block SHALL have port swaps, output, 6 bits: number of swaps performed by the most recent completed sort.

Function
REQ-012 The block SHALL contain an N x 4-bit register array, a load/read index and pass/position counters.
REQ-013 The block SHALL contain exactly one 4-bit unsigned magnitude comparator providing eq, neq, big_a (a>b) and big_b (b>a); it is shared across all compare steps.
REQ-014 The FSM SHALL have exactly three states: LOAD, SORT and DRAIN; reset state is LOAD.
REQ-015 In LOAD, the block SHALL drive in_ready=1 and out_valid=0.
- Each cycle with in_valid&in_ready, in_data SHALL be written to mem[idx] and idx SHALL increment.
REQ-016 After the Nth accepted entry, the FSM SHALL go to SORT on the next edge, with pass=0, pos=0, and the swap counter cleared.
REQ-017 In SORT, the block SHALL perform one compare per cycle on comparator a=mem[pos], b=mem[pos+1].
- If big_a=1, the two entries SHALL be swapped at the clock edge and the swap counter SHALL increment.
- If eq=1 or big_b=1, no swap SHALL occur; equal values are never swapped.
REQ-018 pos SHALL step 0..N-2 and then wrap to 0 while pass increments; SORT SHALL run exactly N-1 passes with no early exit.
- SORT occupies exactly (N-1)^2 cycles; for N=4 this is 9.
REQ-019 busy SHALL be 1 only in SORT; in_ready SHALL be 0 in SORT and DRAIN.
REQ-020 After the last compare, the FSM SHALL enter DRAIN with rd_idx=0; swaps SHALL update to the final swap count on the same edge.
- swaps SHALL hold that value until the next sort completes.
REQ-021 Latency: if the Nth entry is accepted at edge t, out_valid SHALL first be 1 in the cycle after edge t+(N-1)^2.
REQ-022 In DRAIN, the block SHALL drive out_valid=1 and out_data=mem[rd_idx].
- On out_valid&out_ready, rd_idx SHALL increment.
- out_data SHALL remain stable while out_ready=0.
REQ-023 After the Nth transfer in DRAIN, the FSM SHALL return to LOAD on the same edge with idx=0; out_valid SHALL be 0 in the next cycle.
REQ-024 in_valid SHALL be ignored outside LOAD; out_ready SHALL be ignored outside DRAIN.
REQ-025 The block SHALL NOT accept a partial job: fewer than N entries leaves the FSM in LOAD indefinitely.

Reset
REQ-026 While rst=1 at an edge, the block SHALL set: state=LOAD, idx=0, rd_idx=0, pass=0, pos=0, swap counter=0, swaps=0.
- Resulting outputs: in_ready=1, out_valid=0, busy=0.
- out_data SHALL read 0 when out_valid=0.
- mem contents are don't-care after reset.
REQ-027 A reset asserted in any state, including mid-SORT or mid-DRAIN, SHALL abort the job with no further outputs from it; rst has priority over all other inputs.

Verification
REQ-028 Load 9,3,3,0 with out_ready=1 -> exactly 9 busy cycles; out_data sequence 0,3,3,9; swaps=5.
REQ-029 Load 1,2,3,4 (already sorted) -> 9 busy cycles; out 1,2,3,4; swaps=0.
REQ-030 Load 15,10,5,0 -> out 0,5,10,15; swaps=6; out_valid first high 10 cycles after the 4th accept edge.
REQ-031 Load 7,7,7,7 with in_valid gaps and out_ready toggling 1,0,0,1 -> in_ready low during SORT/DRAIN; out_data held 7 while stalled; exactly 4 transfers; in_ready=1 afterwards.
REQ-032 Assert rst for one cycle during the 5th SORT cycle -> next cycle in_ready=1, busy=0, out_valid=0, swaps=0; a new job 2,1,0,3 then outputs 0,1,2,3.
REQ-033 Exhaustive check of the comparator path: all 256 (a,b) pairs from loading pairs with N=2 -> output is min then max; swaps=1 exactly when a>b.

Source files
------------

// File: rtl/sort4_ctrl.sv
// sort4_ctrl: loads N 4-bit entries, bubble-sorts them in place
// with one shared comparator, then drains them in ascending order.
module sort4_ctrl #(
  parameter int N = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [3:0] out_data,
  input  logic       out_ready,
  output logic       busy,
  output logic [5:0] swaps
);

  localparam int AW = $clog2(N);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [AW-1:0]   rd_idx_q, rd_idx_d;
  logic [AW-1:0]   pass_q, pass_d;
  logic [AW-1:0]   pos_q, pos_d;
  logic [AW-1:0]   pos_nx;
  logic [5:0]      cnt_q, cnt_d;
  logic [5:0]      swaps_q, swaps_d;
  logic [3:0]      mem_q [N];
  logic [3:0]      mem_d [N];

  logic [3:0] cmp_a, cmp_b;
  logic       eq, neq, big_a, big_b;
  logic       do_swap;
  logic       pos_last, pass_last;

  assign pos_nx    = pos_q + AW'(1);
  assign pos_last  = (pos_q == AW'(N-2));
  assign pass_last = (pass_q == AW'(N-2));

  // The single comparator shared by every compare step
  assign cmp_a = mem_q[pos_q];
  assign cmp_b = mem_q[pos_nx];
  assign eq    = (cmp_a == cmp_b);
  assign neq   = ~eq;
  assign big_a = (cmp_a > cmp_b);
  assign big_b = (cmp_b > cmp_a);

  always_comb begin
    do_swap = 1'b0;
    unique case (1'b1)
      big_a:     do_swap = neq;
      eq, big_b: do_swap = 1'b0;
      default:   do_swap = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= LOAD;
      idx_q    <= '0;
      rd_idx_q <= '0;
      pass_q   <= '0;
      pos_q    <= '0;
      cnt_q    <= '0;
      swaps_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      rd_idx_q <= rd_idx_d;
      pass_q   <= pass_d;
      pos_q    <= pos_d;
      cnt_q    <= cnt_d;
      swaps_q  <= swaps_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD:
        if (in_valid && idx_q == AW'(N-1))
          state_d = SORT;
      SORT:
        if (pos_last && pass_last)
          state_d = DRAIN;
      DRAIN:
        if (out_ready && rd_idx_q == AW'(N-1))
          state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  always_comb begin
    mem_d    = mem_q;
    idx_d    = idx_q;
    rd_idx_d = rd_idx_q;
    pass_d   = pass_q;
    pos_d    = pos_q;
    cnt_d    = cnt_q;
    swaps_d  = swaps_q;
    unique case (state_q)
      LOAD: begin
        if (in_valid) begin
          mem_d[idx_q] = in_data;
          if (idx_q == AW'(N-1)) begin
            idx_d  = '0;
            pass_d = '0;
            pos_d  = '0;
            cnt_d  = '0;
          end else begin
            idx_d = idx_q + AW'(1);
          end
        end
      end
      SORT: begin
        if (do_swap) begin
          mem_d[pos_q]  = cmp_b;
          mem_d[pos_nx] = cmp_a;
          cnt_d = cnt_q + 6'd1;
        end
        if (pos_last) begin
          pos_d  = '0;
          pass_d = pass_q + AW'(1);
          if (pass_last) begin
            pass_d   = '0;
            rd_idx_d = '0;
            swaps_d  = cnt_d;
          end
        end else begin
          pos_d = pos_nx;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (rd_idx_q == AW'(N-1)) begin
            rd_idx_d = '0;
            idx_d    = '0;
          end else begin
            rd_idx_d = rd_idx_q + AW'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == LOAD);
    out_valid = (state_q == DRAIN);
    busy      = (state_q == SORT);
    out_data  = out_valid ? mem_q[rd_idx_q] : 4'd0;
    swaps     = swaps_q;
  end

endmodule

// File: tb/tb_sort4_ctrl.sv
// tb_sort4_ctrl: random and directed jobs against a sorted-list /
// inversion-count reference, plus all pairs through an N=2 instance.
module tb_sort4_ctrl;

  typedef logic [3:0] job_t [4];

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready;
  logic [3:0] in_data;
  logic       out_valid, out_ready, busy;
  logic [3:0] out_data;
  logic [5:0] swaps;

  logic       in2_valid, in2_ready;
  logic [3:0] in2_data;
  logic       out2_valid, out2_ready, busy2;
  logic [3:0] out2_data;
  logic [5:0] swaps2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sort4_ctrl #(.N(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .swaps(swaps)
  );

  sort4_ctrl #(.N(2)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in2_valid), .in_data(in2_data), .in_ready(in2_ready),
    .out_valid(out2_valid), .out_data(out2_data), .out_ready(out2_ready),
    .busy(busy2), .swaps(swaps2)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: ascending order and number of out-of-order pairs
  task automatic model(input job_t v, output job_t s, output int inv);
    logic [3:0] t;
    s = v;
    inv = 0;
    for (int i = 0; i < 4; i++)
      for (int j = i + 1; j < 4; j++)
        if (v[i] > v[j]) inv++;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 3 - i; j++)
        if (s[j] > s[j+1]) begin
          t = s[j]; s[j] = s[j+1]; s[j+1] = t;
        end
  endtask

  task automatic load4(input job_t v, input bit gaps);
    for (int i = 0; i < 4; i++) begin
      if (gaps)
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          out_ready = 1'($urandom);
          @(negedge clk);
          chk("gap_rdy", in_ready, 1);
        end
      chk("ld_rdy", in_ready, 1);
      chk("ld_vld", out_valid, 0);
      in_valid = 1'b1;
      in_data = v[i];
      out_ready = 1'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic finish_job(input job_t v, input int mode);
    job_t s;
    int inv, k, bc, cnt, guard;
    bit r;
    model(v, s, inv);
    k = 1;
    bc = 0;
    while (!out_valid && k < 100) begin
      if (busy) bc++;
      chk("sort_rdy", in_ready, 0);
      in_valid = 1'($urandom);
      in_data = 4'($urandom);
      out_ready = 1'($urandom);
      @(negedge clk);
      k++;
    end
    chk("busy_cyc", bc, 9);
    chk("latency", k, 10);
    chk("swaps", swaps, inv);
    cnt = 0;
    guard = 0;
    while (cnt < 4 && guard < 200) begin
      chk("dr_vld", out_valid, 1);
      chk("dr_data", out_data, s[cnt]);
      chk("dr_rdy", in_ready, 0);
      chk("dr_busy", busy, 0);
      case (mode)
        0: r = 1'b1;
        1: r = (guard % 4 == 0) || (guard % 4 == 3);
        default: r = 1'($urandom);
      endcase
      out_ready = r;
      in_valid = 1'($urandom);
      in_data = 4'($urandom);
      @(negedge clk);
      if (r) cnt++;
      guard++;
    end
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("xfers", cnt, 4);
    chk("end_vld", out_valid, 0);
    chk("end_data", out_data, 0);
    chk("end_rdy", in_ready, 1);
    chk("end_swaps", swaps, inv);
  endtask

  task automatic run_job(input job_t v, input bit gaps, input int mode);
    load4(v, gaps);
    in_valid = 1'b0;
    finish_job(v, mode);
  endtask

  task automatic job2(input logic [3:0] a, input logic [3:0] b);
    int k;
    chk("p_rdy", in2_ready, 1);
    in2_valid = 1'b1;
    in2_data = a;
    @(negedge clk);
    in2_data = b;
    @(negedge clk);
    in2_valid = 1'b0;
    k = 0;
    while (!out2_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("p_vld", out2_valid, 1);
    chk("p_lat", k, 1);
    chk("p_min", out2_data, (a < b) ? a : b);
    out2_ready = 1'b1;
    @(negedge clk);
    chk("p_max", out2_data, (a < b) ? b : a);
    @(negedge clk);
    out2_ready = 1'b0;
    chk("p_done", out2_valid, 0);
    chk("p_swaps", swaps2, (a > b) ? 1 : 0);
  endtask

  initial begin
    job_t v;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 4'd0;
    out_ready = 1'b0;
    in2_valid = 1'b0;
    in2_data = 4'd0;
    out2_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_rdy", in_ready, 1);
    chk("rst_vld", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_swaps", swaps, 0);
    chk("rst_data", out_data, 0);

    v = '{4'd9, 4'd3, 4'd3, 4'd0};
    run_job(v, 1'b0, 0);
    v = '{4'd1, 4'd2, 4'd3, 4'd4};
    run_job(v, 1'b0, 0);
    v = '{4'd15, 4'd10, 4'd5, 4'd0};
    run_job(v, 1'b0, 0);
    v = '{4'd7, 4'd7, 4'd7, 4'd7};
    run_job(v, 1'b1, 1);

    // Abort mid-sort after a job that left a nonzero swap count
    v = '{4'd15, 4'd10, 4'd5, 4'd0};
    run_job(v, 1'b0, 0);
    v = '{4'd9, 4'd3, 4'd3, 4'd0};
    load4(v, 1'b0);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("ab_rdy", in_ready, 1);
    chk("ab_busy", busy, 0);
    chk("ab_vld", out_valid, 0);
    chk("ab_swaps", swaps, 0);
    repeat (12) begin
      @(negedge clk);
      chk("ab_quiet", out_valid, 0);
    end
    v = '{4'd2, 4'd1, 4'd0, 4'd3};
    run_job(v, 1'b0, 0);

    // Partial job never starts a sort
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data = 4'(i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (20) @(negedge clk);
    chk("part_rdy", in_ready, 1);
    chk("part_busy", busy, 0);
    chk("part_vld", out_valid, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < 4; i++) v[i] = 4'($urandom_range(0, 15));
      run_job(v, 1'b1, 2);
    end

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        job2(4'(a), 4'(b));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
